// File: rtl/power_switch_sequencer.sv
// Staged header power-switch sequencer: enables sleep_n stages one at a time to limit in-rush.
// Define PSW_ACK_CHECK_EN to gate power-up on synchronized vdd_good, with timeout and ON monitor.
module power_switch_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pwr_req,
  input  logic                  i_vdd_good,
  output logic [NUM_STAGES-1:0] o_sleep_n_stages,
  output logic                  o_pwr_ack,
  output logic                  o_pwr_off_ack,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned CNT_W = $clog2(STAGE_DELAY + 1);
  localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {StOff, StRampUp, StOn, StRampDown} state_e;

  state_e                r_state, w_state_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [NUM_STAGES-1:0] r_sleep, w_sleep_d;
  logic                  r_ack, w_ack_d;
  logic                  r_off_ack, w_off_ack_d;
  logic                  r_busy, w_busy_d;
  logic                  r_err, w_err_d;
  logic                  w_go_down, w_go_on;
  logic                  w_delay_done, w_last_set;

`ifdef PSW_ACK_CHECK_EN
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic             r_vdd_meta, r_vdd_sync;
  logic [TMO_W-1:0] r_tmo, w_tmo_d;
  logic             w_tmo_done;

  assign w_tmo_done = (r_tmo == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vdd_meta <= 1'b0;
      r_vdd_sync <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_vdd_meta <= i_vdd_good;
      r_vdd_sync <= r_vdd_meta;
      r_tmo      <= w_tmo_d;
    end
  end
`else
  localparam int unsigned unused_ack_timeout = ACK_TIMEOUT;
  logic w_unused_vdd;
  assign w_unused_vdd = i_vdd_good;
`endif

  assign w_delay_done = (r_cnt == CNT_W'(STAGE_DELAY - 1));
  assign w_last_set   = (r_idx == IDX_W'(NUM_STAGES));

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_idx_d     = r_idx;
    w_sleep_d   = r_sleep;
    w_ack_d     = r_ack;
    w_off_ack_d = r_off_ack;
    w_busy_d    = r_busy;
    w_err_d     = r_err;
    w_go_down   = 1'b0;
    w_go_on     = 1'b0;
`ifdef PSW_ACK_CHECK_EN
    w_tmo_d     = r_tmo;
`endif

    unique case (r_state)
      StOff: begin
        if (i_pwr_req) begin
          w_state_d   = StRampUp;
          w_sleep_d   = NUM_STAGES'(1);
          w_idx_d     = IDX_W'(1);
          w_cnt_d     = '0;
          w_err_d     = 1'b0;
          w_busy_d    = 1'b1;
          w_off_ack_d = 1'b0;
        end
      end
      StRampUp: begin
        if (!i_pwr_req) begin
          w_go_down = 1'b1;
        end else if (!w_last_set) begin
          if (w_delay_done) begin
            w_cnt_d = '0;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
              if (r_idx == IDX_W'(i)) w_sleep_d[i] = 1'b1;
            end
            w_idx_d = r_idx + IDX_W'(1);
`ifdef PSW_ACK_CHECK_EN
            w_tmo_d = '0;
`endif
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end else begin
`ifdef PSW_ACK_CHECK_EN
          // All stages on: hold here until the rail is reported good.
          if (r_vdd_sync) begin
            w_go_on = 1'b1;
          end else if (w_tmo_done) begin
            w_err_d   = 1'b1;
            w_go_down = 1'b1;
          end else begin
            w_tmo_d = r_tmo + TMO_W'(1);
          end
`else
          if (w_delay_done) begin
            w_go_on = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
`endif
        end
      end
      StOn: begin
        if (!i_pwr_req) begin
          w_go_down = 1'b1;
`ifdef PSW_ACK_CHECK_EN
        end else if (!r_vdd_sync) begin
          w_err_d   = 1'b1;
          w_go_down = 1'b1;
`endif
        end
      end
      StRampDown: begin
        if (w_delay_done) begin
          w_state_d   = StOff;
          w_cnt_d     = '0;
          w_off_ack_d = 1'b1;
          w_busy_d    = 1'b0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_d = StOff;
    endcase

    if (w_go_on) begin
      w_state_d = StOn;
      w_cnt_d   = '0;
      w_ack_d   = 1'b1;
      w_busy_d  = 1'b0;
    end
    // Entry into discharge: cut every stage at once and restart the wait timer.
    if (w_go_down) begin
      w_state_d   = StRampDown;
      w_cnt_d     = '0;
      w_idx_d     = '0;
      w_sleep_d   = '0;
      w_ack_d     = 1'b0;
      w_off_ack_d = 1'b0;
      w_busy_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StOff;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sleep   <= '0;
      r_ack     <= 1'b0;
      r_off_ack <= 1'b1;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_idx     <= w_idx_d;
      r_sleep   <= w_sleep_d;
      r_ack     <= w_ack_d;
      r_off_ack <= w_off_ack_d;
      r_busy    <= w_busy_d;
      r_err     <= w_err_d;
    end
  end

  assign o_sleep_n_stages = r_sleep;
  assign o_pwr_ack        = r_ack;
  assign o_pwr_off_ack    = r_off_ack;
  assign o_busy           = r_busy;
  assign o_err            = r_err;

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Table-driven bench for power_switch_sequencer at default parameters, scoreboard-checked.
// Build with PSW_ACK_CHECK_EN defined to exercise the vdd_good handshake variant.
module tb_power_switch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_req;
  logic       vdd_good;
  logic [3:0] sleep_n;
  logic       pwr_ack, pwr_off_ack, busy, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic        req;
    logic        vdd;
    int unsigned hold;
    logic [3:0]  sleep;
    logic        ack;
    logic        off_ack;
    logic        busy;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0] sleep;
    logic       ack;
    logic       off_ack;
    logic       busy;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  power_switch_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pwr_req        (pwr_req),
    .i_vdd_good       (vdd_good),
    .o_sleep_n_stages (sleep_n),
    .o_pwr_ack        (pwr_ack),
    .o_pwr_off_ack    (pwr_off_ack),
    .o_busy           (busy),
    .o_err            (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic req, input logic vdd, input int unsigned hold,
                              input logic [3:0] sleep, input logic ack, input logic off_ack,
                              input logic bsy, input logic e);
    vec_t v;
    v.req = req; v.vdd = vdd; v.hold = hold; v.sleep = sleep;
    v.ack = ack; v.off_ack = off_ack; v.busy = bsy; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input int idx, input exp_t e);
    chk({name, ".sleep"}, idx, 32'(sleep_n), 32'(e.sleep));
    chk({name, ".ack"}, idx, 32'(pwr_ack), 32'(e.ack));
    chk({name, ".off_ack"}, idx, 32'(pwr_off_ack), 32'(e.off_ack));
    chk({name, ".busy"}, idx, 32'(busy), 32'(e.busy));
    chk({name, ".err"}, idx, 32'(err), 32'(e.err));
  endtask

  // Advance one edge and sample 1 time unit later; acks must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("ack_exclusive", cyc, 32'(pwr_ack & pwr_off_ack), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;

`ifdef PSW_ACK_CHECK_EN
    vecs.push_back(mk(1, 0,  1, 4'b0001, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 24, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 63, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  1, 4'b0000, 0, 0, 1, 1));  // timeout 64 after last stage
    vecs.push_back(mk(0, 0,  7, 4'b0000, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  2, 4'b0000, 0, 1, 0, 1));  // err sticky in OFF
    vecs.push_back(mk(1, 0,  1, 4'b0001, 0, 0, 1, 0));  // err cleared on new ramp
    vecs.push_back(mk(1, 0, 24, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  5, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1,  2, 4'b1111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1,  1, 4'b1111, 1, 0, 0, 0));  // ack 8 after last stage
    vecs.push_back(mk(1, 0,  2, 4'b1111, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0,  1, 4'b0000, 0, 0, 1, 1));  // brown-out in ON
    vecs.push_back(mk(0, 0,  8, 4'b0000, 0, 1, 0, 1));
`else
    vecs.push_back(mk(0, 0,  9, 4'b0000, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  1, 4'b0001, 0, 0, 1, 0));  // edge 10
    vecs.push_back(mk(1, 0,  7, 4'b0001, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  1, 4'b0011, 0, 0, 1, 0));  // edge 18
    vecs.push_back(mk(1, 0,  8, 4'b0111, 0, 0, 1, 0));  // edge 26
    vecs.push_back(mk(1, 0,  7, 4'b0111, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  1, 4'b1111, 0, 0, 1, 0));  // edge 34
    vecs.push_back(mk(1, 0,  7, 4'b1111, 0, 0, 1, 0));  // edge 41, still busy
    vecs.push_back(mk(1, 0,  1, 4'b1111, 1, 0, 0, 0));  // edge 42
    vecs.push_back(mk(1, 0, 17, 4'b1111, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 0, 1, 0));  // edge 60
    vecs.push_back(mk(0, 0,  7, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 1, 0, 0));  // edge 68
    vecs.push_back(mk(0, 0,  2, 4'b0000, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0,  1, 4'b0001, 0, 0, 1, 0));  // abort sequence
    vecs.push_back(mk(1, 0,  7, 4'b0001, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  1, 4'b0011, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  3, 4'b0011, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  7, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32, 4'b1111, 0, 0, 1, 0));  // re-request sequence
    vecs.push_back(mk(1, 0,  1, 4'b1111, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  2, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  5, 4'b0000, 0, 0, 1, 0));  // request ignored in ramp-down
    vecs.push_back(mk(1, 0,  1, 4'b0000, 0, 1, 0, 0));  // single OFF cycle
    vecs.push_back(mk(1, 0,  1, 4'b0001, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  8, 4'b0011, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  8, 4'b0000, 0, 1, 0, 0));
`endif

    rst = 1'b0;
    pwr_req = 1'b0;
    vdd_good = 1'b0;
    #1 rst = 1'b1;
    #2;
    e = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    chk_outs("reset", 0, e);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      pwr_req  = vecs[i].req;
      vdd_good = vecs[i].vdd;
      sb.push_back('{vecs[i].sleep, vecs[i].ack, vecs[i].off_ack, vecs[i].busy, vecs[i].err});
      repeat (vecs[i].hold) tick();
      e = sb.pop_front();
      chk_outs("vec", i, e);
    end

    // Reset asserted asynchronously mid-ramp with three stages on.
    pwr_req  = 1'b1;
    vdd_good = 1'b0;
    repeat (17) tick();
    chk("midramp.sleep", 0, 32'(sleep_n), 32'(4'b0111));
    #2 rst = 1'b1;
    #1;
    e = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    chk_outs("async_reset", 0, e);
    pwr_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk_outs("post_reset", 0, e);

    // Bounded waits for full ramp-up and discharge latency.
`ifdef PSW_ACK_CHECK_EN
    vdd_good = 1'b1;
`endif
    repeat (3) tick();
    pwr_req = 1'b1;
    n = 0;
    while (!pwr_ack && n < 100) begin
      tick();
      n++;
    end
`ifdef PSW_ACK_CHECK_EN
    chk("ramp_latency", 0, 32'(n), 32'(26));
`else
    chk("ramp_latency", 0, 32'(n), 32'(33));
`endif
    pwr_req = 1'b0;
    n = 0;
    while (!pwr_off_ack && n < 100) begin
      tick();
      n++;
    end
    chk("off_latency", 0, 32'(n), 32'(9));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
